prescale_ratio_ctrl: RTL and testbench

Parametrised successor to the fixed four-way prescale mux. Decodes a power-of-two UART prescale value into the RX clock-divider ratio (ratio = MAX_PRESCALE / prescale) over a configurable legal range. A new setting is qualified for stability, then applied only on a divider period boundary, so the divider never sees a mid-period ratio change. Sits between the register file (prescale config) and the RX clock divider.

---
 rtl/prescale_ratio_ctrl.sv | 150 +++++++++++++++
 tb/tb_prescale_ratio_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prescale_ratio_ctrl.sv
// Decodes a power-of-two prescale into the RX divider ratio and applies it only on a divider boundary.
// Optional `define PRESCALE_EDGE_TIMEOUT_EN forces the apply after TIMEOUT_CYCLES without an edge.
module prescale_ratio_ctrl #(
    parameter int SEL_WIDTH       = 6,
    parameter int DIV_RATIO_WIDTH = 8,
    parameter int MIN_LOG2        = 2,
    parameter int MAX_LOG2        = 5,
    parameter int STABLE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [SEL_WIDTH-1:0]       prescale,
    input  logic                       cfg_valid,
    input  logic                       div_edge,
    output logic [DIV_RATIO_WIDTH-1:0] div_ratio,
    output logic                       ratio_update,
    output logic                       pending,
    output logic                       cfg_err
);

    if (MAX_LOG2 > SEL_WIDTH - 1 || MAX_LOG2 - MIN_LOG2 > DIV_RATIO_WIDTH - 1 ||
        MIN_LOG2 < 0 || MIN_LOG2 > MAX_LOG2 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("prescale_ratio_ctrl: illegal parameter combination");
    end

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, QUAL, WAIT_EDGE} state_e;

    function automatic logic is_legal(input logic [SEL_WIDTH-1:0] p);
        logic ok;
        ok = 1'b0;
        for (int k = MIN_LOG2; k <= MAX_LOG2; k++) begin
            if (p == (SEL_WIDTH'(1) << k)) ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [DIV_RATIO_WIDTH-1:0] ratio_of(input logic [SEL_WIDTH-1:0] p);
        logic [DIV_RATIO_WIDTH-1:0] r;
        r = '0;
        for (int k = MIN_LOG2; k <= MAX_LOG2; k++) begin
            if (p == (SEL_WIDTH'(1) << k)) r = DIV_RATIO_WIDTH'(1) << (MAX_LOG2 - k);
        end
        return r;
    endfunction

    state_e                     state_q, state_d;
    logic [SEL_WIDTH-1:0]       cand_q, cand_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DIV_RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic                       upd_q, upd_d;
    logic                       err_q, err_d;
    logic                       in_legal;
    logic [DIV_RATIO_WIDTH-1:0] in_ratio, cand_ratio;
    logic                       timeout_hit;

    assign in_legal   = is_legal(prescale);
    assign in_ratio   = ratio_of(prescale);
    assign cand_ratio = ratio_of(cand_q);

`ifdef PRESCALE_EDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign timeout_hit = (state_q == WAIT_EDGE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    // Counts only while staying in WAIT_EDGE, so every exit leaves it cleared.
    assign tmo_d = (state_q == WAIT_EDGE && state_d == WAIT_EDGE) ? tmo_q + TMO_W'(1) : '0;

    always_ff @(posedge CLK) begin
        if (RST) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every output of this block is defaulted first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        if (cfg_valid) begin
            // A fresh write overrides whatever candidate is in flight, including a same-cycle edge.
            if (!in_legal) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else if (in_ratio == ratio_q) begin
                state_d = IDLE;
            end else begin
                cand_d  = prescale;
                cnt_d   = '0;
                state_d = QUAL;
            end
        end else begin
            unique case (state_q)
                QUAL: begin
                    if (prescale == cand_q) begin
                        if (cnt_q == CNT_LAST) state_d = WAIT_EDGE;
                        else                   cnt_d   = cnt_q + CNT_W'(1);
                    end else if (!in_legal) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cand_d = prescale;
                        cnt_d  = '0;
                    end
                end
                WAIT_EDGE: begin
                    if (div_edge || timeout_hit) begin
                        ratio_d = cand_ratio;
                        upd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            ratio_q <= DIV_RATIO_WIDTH'(1);
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    assign div_ratio    = ratio_q;
    assign ratio_update = upd_q;
    assign pending      = (state_q != IDLE);
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_prescale_ratio_ctrl.sv
// Self-checking bench for prescale_ratio_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_prescale_ratio_ctrl;

    localparam int SEL_WIDTH       = 6;
    localparam int DIV_RATIO_WIDTH = 8;
    localparam int MIN_LOG2        = 2;
    localparam int MAX_LOG2        = 5;
    localparam int STABLE_CYCLES   = 4;
    localparam int TIMEOUT_CYCLES  = 10;
    localparam int MAX_PRESCALE    = 1 << MAX_LOG2;
`ifdef PRESCALE_EDGE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                       CLK = 1'b0;
    logic                       RST = 1'b1;
    logic [SEL_WIDTH-1:0]       prescale = '0;
    logic                       cfg_valid = 1'b0;
    logic                       div_edge = 1'b0;
    logic [DIV_RATIO_WIDTH-1:0] div_ratio;
    logic                       ratio_update;
    logic                       pending;
    logic                       cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    prescale_ratio_ctrl #(
        .SEL_WIDTH(SEL_WIDTH), .DIV_RATIO_WIDTH(DIV_RATIO_WIDTH), .MIN_LOG2(MIN_LOG2),
        .MAX_LOG2(MAX_LOG2), .STABLE_CYCLES(STABLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK(CLK), .RST(RST), .prescale(prescale), .cfg_valid(cfg_valid), .div_edge(div_edge),
        .div_ratio(div_ratio), .ratio_update(ratio_update), .pending(pending), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    // Reference model: tracks whether a candidate exists, how many stable cycles it has shown,
    // and how long it has waited for a boundary.
    int m_ratio;
    bit m_have, m_qualified, m_upd, m_err;
    int m_cand, m_seen, m_waited;

    function automatic bit m_legal(input int p);
        return p != 0 && (p & (p - 1)) == 0 && p >= (1 << MIN_LOG2) && p <= MAX_PRESCALE;
    endfunction

    task automatic model_reset();
        m_ratio = 1; m_have = 0; m_qualified = 0; m_upd = 0; m_err = 0;
        m_cand = 0; m_seen = 0; m_waited = 0;
    endtask

    task automatic model_step(input bit v, input int p, input bit e);
        m_upd = 0;
        m_err = 0;
        if (v) begin
            if (!m_legal(p)) begin
                m_err = 1; m_have = 0;
            end else if (MAX_PRESCALE / p == m_ratio) begin
                m_have = 0;
            end else begin
                m_have = 1; m_qualified = 0; m_cand = p; m_seen = 0;
            end
        end else if (m_have && !m_qualified) begin
            if (p == m_cand) begin
                m_seen++;
                if (m_seen == STABLE_CYCLES) begin
                    m_qualified = 1; m_waited = 0;
                end
            end else if (!m_legal(p)) begin
                m_err = 1; m_have = 0;
            end else begin
                m_cand = p; m_seen = 0;
            end
        end else if (m_have) begin
            if (e || (TMO_EN && m_waited == TIMEOUT_CYCLES - 1)) begin
                m_ratio = MAX_PRESCALE / m_cand; m_upd = 1; m_have = 0;
            end else begin
                m_waited++;
            end
        end
    endtask

    task automatic step(input bit v, input logic [SEL_WIDTH-1:0] p, input bit e);
        @(negedge CLK);
        cfg_valid = v; prescale = p; div_edge = e;
        @(posedge CLK);
        model_step(v, int'(p), e);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; cfg_valid = 1'b0; div_edge = 1'b0; prescale = '0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if ({div_ratio, pending, ratio_update, cfg_err} !== {8'd1, 3'b000}) begin
            n_fail++;
            $display("FAIL reset: ratio=%0d pend=%b upd=%b err=%b, need ratio=1 pend=0 upd=0 err=0",
                     div_ratio, pending, ratio_update, cfg_err);
        end
    endtask

    task automatic test_basic_apply();
        do_reset();
        step(1, 6'd8, 0);
        for (int c = 1; c <= STABLE_CYCLES; c++) begin
            step(0, 6'd8, c >= 3);
            n_tests++;
            if (pending !== 1'b1 || div_ratio !== 8'd1 || ratio_update !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_qual c%0d: pend=%b ratio=%0d upd=%b, need 1/1/0", c, pending, div_ratio, ratio_update);
            end
        end
        step(0, 6'd8, 1);
        n_tests++;
        if (div_ratio !== 8'd4 || ratio_update !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_apply: ratio=%0d upd=%b pend=%b, need 4/1/0", div_ratio, ratio_update, pending);
        end
        step(0, 6'd8, 0);
        n_tests++;
        if (ratio_update !== 1'b0 || div_ratio !== 8'd4) begin
            n_fail++;
            $display("FAIL basic_pulse_width: upd=%b ratio=%0d, need 0/4", ratio_update, div_ratio);
        end
    endtask

    task automatic test_illegal();
        logic [SEL_WIDTH-1:0] bad [4] = '{6'd12, 6'd0, 6'd2, 6'd48};
        do_reset();
        foreach (bad[i]) begin
            step(1, bad[i], 0);
            n_tests++;
            if (cfg_err !== 1'b1 || div_ratio !== 8'd1 || pending !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_%0d: err=%b ratio=%0d pend=%b, need 1/1/0", bad[i], cfg_err, div_ratio, pending);
            end
            step(0, bad[i], 0);
            n_tests++;
            if (cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_width_%0d: err=%b need 0", bad[i], cfg_err);
            end
        end
        step(1, 6'd8, 0);
        step(0, 6'd12, 0);
        n_tests++;
        if (cfg_err !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_in_qual: err=%b pend=%b, need 1/0", cfg_err, pending);
        end
        step(1, 6'd32, 0);
        n_tests++;
        if (pending !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL same_as_current: pend=%b err=%b, need 0/0", pending, cfg_err);
        end
    endtask

    task automatic test_restart();
        do_reset();
        step(1, 6'd16, 0);
        step(0, 6'd16, 0);
        step(0, 6'd4, 0);
        for (int c = 0; c < STABLE_CYCLES; c++) begin
            step(0, 6'd4, 1);
            n_tests++;
            if (pending !== 1'b1 || div_ratio !== 8'd1) begin
                n_fail++;
                $display("FAIL restart_qual c%0d: pend=%b ratio=%0d, need 1/1", c, pending, div_ratio);
            end
        end
        step(0, 6'd4, 1);
        n_tests++;
        if (div_ratio !== 8'd8 || ratio_update !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_apply: ratio=%0d upd=%b pend=%b, need 8/1/0", div_ratio, ratio_update, pending);
        end
    endtask

    task automatic test_edge_collision();
        do_reset();
        step(1, 6'd4, 0);
        for (int c = 0; c < STABLE_CYCLES + 1; c++) step(0, 6'd4, 0);
        n_tests++;
        if (pending !== 1'b1 || div_ratio !== 8'd1) begin
            n_fail++;
            $display("FAIL collision_wait: pend=%b ratio=%0d, need 1/1", pending, div_ratio);
        end
        step(1, 6'd32, 1);
        n_tests++;
        if (pending !== 1'b0 || div_ratio !== 8'd1 || ratio_update !== 1'b0) begin
            n_fail++;
            $display("FAIL collision: pend=%b ratio=%0d upd=%b, need 0/1/0", pending, div_ratio, ratio_update);
        end
        step(0, 6'd32, 1);
        n_tests++;
        if (div_ratio !== 8'd1 || ratio_update !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_edge: ratio=%0d upd=%b, need 1/0", div_ratio, ratio_update);
        end
    endtask

    task automatic test_timeout();
        bit stuck_ok;
        do_reset();
        step(1, 6'd4, 0);
        for (int c = 0; c < STABLE_CYCLES; c++) step(0, 6'd4, 0);
        stuck_ok = 1'b1;
        if (TMO_EN) begin
            for (int c = 0; c < TIMEOUT_CYCLES - 1; c++) begin
                step(0, 6'd4, 0);
                if (div_ratio !== 8'd1 || pending !== 1'b1) stuck_ok = 1'b0;
            end
            n_tests++;
            if (!stuck_ok) begin
                n_fail++;
                $display("FAIL timeout_early: applied before %0d cycles", TIMEOUT_CYCLES);
            end
            step(0, 6'd4, 0);
            n_tests++;
            if (div_ratio !== 8'd8 || ratio_update !== 1'b1 || pending !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_apply: ratio=%0d upd=%b pend=%b, need 8/1/0", div_ratio, ratio_update, pending);
            end
        end else begin
            for (int c = 0; c < 1000; c++) begin
                step(0, 6'd4, 0);
                if (div_ratio !== 8'd1 || pending !== 1'b1) stuck_ok = 1'b0;
            end
            n_tests++;
            if (!stuck_ok) begin
                n_fail++;
                $display("FAIL no_timeout: ratio=%0d pend=%b, need 1/1 throughout", div_ratio, pending);
            end
            step(0, 6'd4, 1);
            n_tests++;
            if (div_ratio !== 8'd8 || ratio_update !== 1'b1) begin
                n_fail++;
                $display("FAIL late_edge_apply: ratio=%0d upd=%b, need 8/1", div_ratio, ratio_update);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 6'd16, 0);
        for (int c = 0; c < STABLE_CYCLES + 1; c++) step(0, 6'd16, 1);
        step(1, 6'd8, 0);
        step(0, 6'd8, 0);
        do_reset();
        #1;
        n_tests++;
        if (div_ratio !== 8'd1 || pending !== 1'b0 || ratio_update !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: ratio=%0d pend=%b upd=%b, need 1/0/0", div_ratio, pending, ratio_update);
        end
        for (int c = 0; c < STABLE_CYCLES + 2; c++) step(0, 6'd8, 1);
        n_tests++;
        if (div_ratio !== 8'd1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: ratio=%0d pend=%b, need 1/0", div_ratio, pending);
        end
    endtask

    task automatic test_random();
        logic [SEL_WIDTH-1:0] p;
        bit v, e;
        do_reset();
        p = 6'd32;
        for (int c = 0; c < 3000; c++) begin
            v = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 5) == 0);
            if (v || $urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 9) < 7) p = SEL_WIDTH'(1 << $urandom_range(MIN_LOG2, MAX_LOG2));
                else                          p = SEL_WIDTH'($urandom_range(0, (1 << SEL_WIDTH) - 1));
            end
            step(v, p, e);
            n_tests++;
            if (div_ratio !== DIV_RATIO_WIDTH'(m_ratio) || ratio_update !== m_upd ||
                pending !== m_have || cfg_err !== m_err) begin
                n_fail++;
                $display("FAIL random c%0d: ratio=%0d upd=%b pend=%b err=%b, need %0d/%b/%b/%b",
                         c, div_ratio, ratio_update, pending, cfg_err, m_ratio, m_upd, m_have, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_apply();
        test_illegal();
        test_restart();
        test_edge_collision();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
